// File: rtl/r5p_tcb_arbiter.sv
// r5p_tcb_arbiter: round-robin arbiter sharing one TCB subordinate port
// between N managers. It supports lock sequences and routes delayed
// responses back to the manager that issued each request.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   sub_vld/wen/ren/xen/lck [N]   per-manager request controls
//   sub_adr [N*ADR], sub_siz [N*2], sub_wdt [N*DAT]  per-manager request payload
//   sub_rdt [N*DAT], sub_err [N]  routed response
//   sub_rdy [N]                   per-manager ready (only the granted one follows man_rdy)
//   man_vld/wen/ren/xen/lck, man_adr, man_siz, man_wdt  muxed request to subordinate
//   man_rdt, man_err, man_rdy     subordinate response / ready
//
// Parameters: N managers (2..8), ADR/DAT widths, DLY response delay (0..4).

// Per-manager response steering: pass the subordinate response through
// only when the pending response belongs to this port.
module r5p_tcb_arbiter_rsp #(
  parameter int unsigned PW  = 1,
  parameter int unsigned DAT = 32,
  parameter int unsigned IDX = 0
)(
  input  logic           rsp_vld,
  input  logic [PW-1:0]  rsp_idx,
  input  logic [DAT-1:0] man_rdt,
  input  logic           man_err,
  output logic [DAT-1:0] rdt,
  output logic           err
);
  logic w_sel;
  assign w_sel = rsp_vld && (rsp_idx == PW'(IDX));
  assign rdt   = w_sel ? man_rdt : '0;
  assign err   = w_sel & man_err;
endmodule

module r5p_tcb_arbiter #(
  parameter int unsigned N   = 2,
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned DLY = 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       sub_vld,
  input  logic [N-1:0]       sub_wen,
  input  logic [N-1:0]       sub_ren,
  input  logic [N-1:0]       sub_xen,
  input  logic [N-1:0]       sub_lck,
  input  logic [N*ADR-1:0]   sub_adr,
  input  logic [N*2-1:0]     sub_siz,
  input  logic [N*DAT-1:0]   sub_wdt,
  output logic [N*DAT-1:0]   sub_rdt,
  output logic [N-1:0]       sub_err,
  output logic [N-1:0]       sub_rdy,
  output logic               man_vld,
  output logic               man_wen,
  output logic               man_ren,
  output logic               man_xen,
  output logic               man_lck,
  output logic [ADR-1:0]     man_adr,
  output logic [1:0]         man_siz,
  output logic [DAT-1:0]     man_wdt,
  input  logic [DAT-1:0]     man_rdt,
  input  logic               man_err,
  input  logic               man_rdy
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic           wen;
    logic           ren;
    logic           xen;
    logic           lck;
    logic [ADR-1:0] adr;
    logic [1:0]     siz;
    logic [DAT-1:0] wdt;
  } req_t;

  req_t                    w_req [N];
  req_t                    w_mreq;
  logic [N-1:0][ADR-1:0]   w_adr;
  logic [N-1:0][1:0]       w_siz;
  logic [N-1:0][DAT-1:0]   w_wdt;
  logic [N-1:0][DAT-1:0]   w_rdt;
  logic [N-1:0]            w_lck_oh;
  logic [N-1:0]            w_elig;
  logic                    w_gnt_vld;
  logic [PW-1:0]           w_gnt;
  logic [PW-1:0]           w_ptr_nxt;
  logic                    w_hs;
  logic                    w_rsp_vld;
  logic [PW-1:0]           w_rsp_idx;

  logic [PW-1:0]           r_ptr;
  logic                    r_lck_act;
  logic [PW-1:0]           r_lck_idx;

  assign w_adr = sub_adr;
  assign w_siz = sub_siz;
  assign w_wdt = sub_wdt;

  for (genvar i = 0; i < N; i++) begin : g_req
    assign w_req[i] = '{wen: sub_wen[i], ren: sub_ren[i], xen: sub_xen[i],
                        lck: sub_lck[i], adr: w_adr[i], siz: w_siz[i], wdt: w_wdt[i]};
  end

  // A held lock narrows eligibility to its owner, even if the owner is idle.
  assign w_lck_oh = N'(1) << r_lck_idx;
  assign w_elig   = rst ? '0 : (r_lck_act ? (sub_vld & w_lck_oh) : sub_vld);

  // Round-robin search starting at the priority pointer, wrapping modulo N.
  always_comb begin
    int j;
    j         = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = 0; k < int'(N); k++) begin
      j = (int'(r_ptr) + k) % int'(N);
      if (!w_gnt_vld && w_elig[j]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = PW'(j);
      end
    end
  end

  assign w_mreq  = w_gnt_vld ? w_req[w_gnt] : '0;
  assign man_vld = w_gnt_vld;
  assign man_wen = w_mreq.wen;
  assign man_ren = w_mreq.ren;
  assign man_xen = w_mreq.xen;
  assign man_lck = w_mreq.lck;
  assign man_adr = w_mreq.adr;
  assign man_siz = w_mreq.siz;
  assign man_wdt = w_mreq.wdt;

  assign sub_rdy   = w_gnt_vld ? (N'(man_rdy) << w_gnt) : '0;
  assign w_hs      = w_gnt_vld & man_rdy;
  assign w_ptr_nxt = (w_gnt == PW'(N-1)) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_lck_act <= 1'b0;
      r_lck_idx <= '0;
    end else if (w_hs) begin
      r_ptr <= w_ptr_nxt;
      if (w_mreq.lck) begin
        r_lck_act <= 1'b1;
        r_lck_idx <= w_gnt;
      end else if (r_lck_act && (w_gnt == r_lck_idx)) begin
        r_lck_act <= 1'b0;
      end
    end
  end

  // Response routing: the grant index travels alongside the subordinate's
  // fixed response delay so back-to-back responses stay attributed.
  if (DLY == 0) begin : g_dly0
    assign w_rsp_vld = w_hs;
    assign w_rsp_idx = w_gnt;
  end else begin : g_dly
    logic [DLY-1:0]          r_dly_vld;
    logic [DLY-1:0][PW-1:0]  r_dly_idx;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_dly_vld <= '0;
        r_dly_idx <= '0;
      end else begin
        r_dly_vld[0] <= w_hs;
        r_dly_idx[0] <= w_gnt;
        for (int i = 1; i < int'(DLY); i++) begin
          r_dly_vld[i] <= r_dly_vld[i-1];
          r_dly_idx[i] <= r_dly_idx[i-1];
        end
      end
    end

    // The stage registers only clear at the edge; mask during reset.
    assign w_rsp_vld = r_dly_vld[DLY-1] & ~rst;
    assign w_rsp_idx = r_dly_idx[DLY-1];
  end

  for (genvar i = 0; i < N; i++) begin : g_rsp
    r5p_tcb_arbiter_rsp #(.PW(PW), .DAT(DAT), .IDX(i)) u_rsp (
      .rsp_vld (w_rsp_vld),
      .rsp_idx (w_rsp_idx),
      .man_rdt (man_rdt),
      .man_err (man_err),
      .rdt     (w_rdt[i]),
      .err     (sub_err[i])
    );
  end

  assign sub_rdt = w_rdt;
endmodule

// File: tb/tb_r5p_tcb_arbiter.sv
// Directed bench for r5p_tcb_arbiter with N=2, DLY=1. The subordinate model
// answers every handshake one cycle later with {16'hC0DE, adr[15:0]} and
// flags an error for address 0xFFFF_FFF0.
module tb_r5p_tcb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sub_vld, sub_wen, sub_ren, sub_xen, sub_lck;
  logic [63:0] sub_adr;
  logic [3:0]  sub_siz;
  logic [63:0] sub_wdt;
  logic [63:0] sub_rdt;
  logic [1:0]  sub_err, sub_rdy;
  logic        man_vld, man_wen, man_ren, man_xen, man_lck;
  logic [31:0] man_adr;
  logic [1:0]  man_siz;
  logic [31:0] man_wdt;
  logic [31:0] man_rdt;
  logic        man_err;
  logic        man_rdy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  r5p_tcb_arbiter #(.N(2), .ADR(32), .DAT(32), .DLY(1)) dut (
    .clk(clk), .rst(rst),
    .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_ren(sub_ren), .sub_xen(sub_xen),
    .sub_lck(sub_lck), .sub_adr(sub_adr), .sub_siz(sub_siz), .sub_wdt(sub_wdt),
    .sub_rdt(sub_rdt), .sub_err(sub_err), .sub_rdy(sub_rdy),
    .man_vld(man_vld), .man_wen(man_wen), .man_ren(man_ren), .man_xen(man_xen),
    .man_lck(man_lck), .man_adr(man_adr), .man_siz(man_siz), .man_wdt(man_wdt),
    .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy)
  );

  // Subordinate model with a one-cycle response delay.
  always @(posedge clk) begin
    if (man_vld && man_rdy) begin
      man_rdt <= {16'hC0DE, man_adr[15:0]};
      man_err <= (man_adr == 32'hFFFF_FFF0);
    end else begin
      man_rdt <= '0;
      man_err <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    man_rdt = '0; man_err = 1'b0;
    rst = 1'b1; man_rdy = 1'b1;
    sub_vld = 2'b11; sub_wen = '0; sub_ren = 2'b11; sub_xen = '0; sub_lck = '0;
    sub_siz = 4'b1010; sub_wdt = '0;
    sub_adr = {32'h0000_0200, 32'h0000_0100};
    tick(); tick();
    settle();
    chk("rst_man_vld", man_vld, 0);
    chk("rst_sub_rdy", sub_rdy, 0);
    chk("rst_sub_rdt", sub_rdt, 0);
    chk("rst_sub_err", sub_err, 0);

    // Reset priority: alternating grants starting at manager 0.
    rst = 1'b0; settle();
    chk("rr0_rdy", sub_rdy, 2'b01);
    chk("rr0_adr", man_adr, 32'h100);
    chk("rr0_siz", man_siz, 2'b10);
    tick();
    chk("rr1_rdy", sub_rdy, 2'b10);
    chk("rr1_adr", man_adr, 32'h200);
    chk("rr1_rdt", sub_rdt, {32'h0, 32'hC0DE_0100});
    tick();
    chk("rr2_rdy", sub_rdy, 2'b01);
    chk("rr2_rdt", sub_rdt, {32'hC0DE_0200, 32'h0});
    tick();
    chk("rr3_rdy", sub_rdy, 2'b10);
    chk("rr3_adr", man_adr, 32'h200);
    tick();

    // Backpressure with manager 1 alone.
    sub_vld = 2'b10; man_rdy = 1'b0; sub_adr[63:32] = 32'h300; settle();
    chk("bp_rsp1", sub_rdt, {32'hC0DE_0200, 32'h0});
    for (int c = 0; c < 3; c++) begin
      chk("bp_rdy", sub_rdy, 2'b00);
      chk("bp_vld", man_vld, 1'b1);
      chk("bp_adr", man_adr, 32'h300);
      if (c < 2) tick();
    end
    tick();
    chk("bp_norsp", sub_rdt, 0);
    man_rdy = 1'b1; settle();
    chk("bp_hs_rdy", sub_rdy, 2'b10);
    tick();

    // Response routing: m0 then m1 back to back; ptr is 0 so m0 goes first.
    sub_vld = 2'b11; sub_adr = {32'h8000_0004, 32'h8000_0000}; settle();
    chk("rt_bp_rsp", sub_rdt, {32'hC0DE_0300, 32'h0});
    chk("rt0_rdy", sub_rdy, 2'b01);
    chk("rt0_adr", man_adr, 32'h8000_0000);
    tick();
    chk("rt1_rdy", sub_rdy, 2'b10);
    chk("rt1_adr", man_adr, 32'h8000_0004);
    chk("rt0_rdt", sub_rdt, {32'h0, 32'hC0DE_0000});
    tick();
    sub_vld = 2'b00; settle();
    chk("rt1_rdt", sub_rdt, {32'hC0DE_0004, 32'h0});
    chk("idle_vld", man_vld, 1'b0);
    chk("idle_adr", man_adr, 32'h0);
    tick();

    // Lock: manager 1 locks, manager 0 starves until an unlocked transfer.
    sub_vld = 2'b10; sub_lck = 2'b10; sub_adr[63:32] = 32'h801f_ff80; settle();
    chk("lk0_rdy", sub_rdy, 2'b10);
    chk("lk0_lck", man_lck, 1'b1);
    tick();
    sub_vld = 2'b11; settle();
    chk("lk1_rdy", sub_rdy, 2'b10);
    tick();
    sub_vld = 2'b01; settle();
    chk("lk_idle_vld", man_vld, 1'b0);
    chk("lk_idle_rdy", sub_rdy, 2'b00);
    tick();
    chk("lk_idle2_vld", man_vld, 1'b0);
    sub_vld = 2'b11; sub_lck = 2'b00; sub_adr[63:32] = 32'h801f_ff84; settle();
    chk("lk_rel_rdy", sub_rdy, 2'b10);
    chk("lk_rel_lck", man_lck, 1'b0);
    tick();
    chk("lk_after_rdy", sub_rdy, 2'b01);
    chk("lk_after_adr", man_adr, 32'h8000_0000);
    tick();

    // Error routing for manager 0.
    sub_vld = 2'b01; sub_adr[31:0] = 32'hFFFF_FFF0; settle();
    chk("er_rdt_prev", sub_rdt, {32'h0, 32'hC0DE_0000});
    chk("er_rdy", sub_rdy, 2'b01);
    tick();
    sub_vld = 2'b00; settle();
    chk("er_err", sub_err, 2'b01);
    tick();
    chk("er_clear", sub_err, 2'b00);

    // Reset mid-flight: response of the last handshake must be discarded.
    sub_vld = 2'b01; sub_adr = {32'h500, 32'h400}; settle();
    chk("mf_rdy", sub_rdy, 2'b01);
    tick();
    rst = 1'b1; sub_vld = 2'b11; settle();
    chk("mf_rst_rdt", sub_rdt, 0);
    chk("mf_rst_vld", man_vld, 1'b0);
    chk("mf_rst_rdy", sub_rdy, 2'b00);
    tick();
    rst = 1'b0; settle();
    chk("mf_post_rdt", sub_rdt, 0);
    chk("mf_post_err", sub_err, 0);
    chk("mf_post_rdy", sub_rdy, 2'b01);
    chk("mf_post_adr", man_adr, 32'h400);
    tick();
    chk("mf_post2_rdy", sub_rdy, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
